// File: rtl/node_ram_arbiter.sv
// node_ram_arbiter: shares one 2-cycle-latency RAM port between three
// requesters (0=build, 1=search, 2=display). Round-robin arbitration with an
// optional lock so a requester can chain up to four accesses (read-modify-write).
//
// Handshake: a requester raises req[i] and holds addr/we/wdata stable while
// gnt[i] is high. The access is committed once gnt[i] rises; dropping req
// afterwards does not abort it. done[i] pulses for one cycle when the access
// completes, and rdata carries the read word in that same cycle. Holding
// lock[i] and req[i] during the done cycle chains another access without
// releasing gnt[i].
module node_ram_arbiter (
  input  logic        clk,
  input  logic        program_reset,
  input  logic [2:0]  req,
  input  logic [2:0]  lock,
  input  logic [2:0]  we,
  input  logic [23:0] addr,
  input  logic [47:0] wdata,
  input  logic [15:0] ram_q,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [15:0] rdata,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic        busy,
  output logic [1:0]  current_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0] r_state;
  logic [1:0] r_owner;
  logic [1:0] r_last_owner;
  logic [1:0] r_lock_cnt;

  logic [1:0]  w_cand0;
  logic [1:0]  w_cand1;
  logic [1:0]  w_cand2;
  logic [1:0]  w_next_owner;
  logic [2:0]  w_owner_oh;
  logic        w_own_req;
  logic        w_own_lock;
  logic        w_own_we;
  logic [7:0]  w_own_addr;
  logic [15:0] w_own_wdata;

  // Round-robin search order: the requester after last_owner comes first.
  always_comb begin
    w_cand0      = (r_last_owner == 2'd2) ? 2'd0 : r_last_owner + 2'd1;
    w_cand1      = (w_cand0 == 2'd2) ? 2'd0 : w_cand0 + 2'd1;
    w_cand2      = (w_cand1 == 2'd2) ? 2'd0 : w_cand1 + 2'd1;
    w_next_owner = w_cand2;
    if (req[w_cand0])      w_next_owner = w_cand0;
    else if (req[w_cand1]) w_next_owner = w_cand1;
  end

  // Select the current owner's request signals; inputs of others are ignored.
  always_comb begin
    w_own_req   = req[0];
    w_own_lock  = lock[0];
    w_own_we    = we[0];
    w_own_addr  = addr[7:0];
    w_own_wdata = wdata[15:0];
    w_owner_oh  = 3'b001;
    case (r_owner)
      2'd1: begin
        w_own_req   = req[1];
        w_own_lock  = lock[1];
        w_own_we    = we[1];
        w_own_addr  = addr[15:8];
        w_own_wdata = wdata[31:16];
        w_owner_oh  = 3'b010;
      end
      2'd2: begin
        w_own_req   = req[2];
        w_own_lock  = lock[2];
        w_own_we    = we[2];
        w_own_addr  = addr[23:16];
        w_own_wdata = wdata[47:32];
        w_owner_oh  = 3'b100;
      end
      default: ;
    endcase
  end

  // Arbitration FSM: IDLE -> ACCESS -> WAIT -> DONE, with locked chaining.
  always_ff @(posedge clk) begin
    if (program_reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd2;
      r_lock_cnt   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_owner <= w_next_owner;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: r_state <= S_WAIT;
        S_WAIT:   r_state <= S_DONE;
        default: begin
          r_last_owner <= r_owner;
          if (w_own_lock && w_own_req && (r_lock_cnt != 2'd3)) begin
            r_state    <= S_ACCESS;
            r_lock_cnt <= r_lock_cnt + 2'd1;
          end else begin
            r_state    <= S_IDLE;
            r_lock_cnt <= 2'd0;
          end
        end
      endcase
    end
  end

  // Outputs decoded from state; RAM bus is zeroed whenever it is not in use.
  always_comb begin
    busy          = (r_state != S_IDLE);
    gnt           = busy ? w_owner_oh : 3'b000;
    done          = (r_state == S_DONE) ? w_owner_oh : 3'b000;
    rdata         = (r_state == S_DONE) ? ram_q : 16'h0000;
    ram_we        = (r_state == S_ACCESS) && w_own_we;
    ram_addr      = (r_state == S_ACCESS) ? w_own_addr : 8'h00;
    ram_wdata     = (r_state == S_ACCESS) ? w_own_wdata : 16'h0000;
    current_state = r_state;
  end

endmodule

// File: tb/tb_node_ram_arbiter.sv
// Bench for node_ram_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level model of the arbiter.
module tb_node_ram_arbiter;

  logic        clk = 1'b0;
  logic        program_reset;
  logic [2:0]  req, lock, we;
  logic [23:0] addr;
  logic [47:0] wdata;
  logic [15:0] ram_q;
  logic [2:0]  gnt, done;
  logic [15:0] rdata;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we, busy;
  logic [1:0]  current_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  node_ram_arbiter dut (
    .clk(clk), .program_reset(program_reset), .req(req), .lock(lock),
    .we(we), .addr(addr), .wdata(wdata), .ram_q(ram_q), .gnt(gnt),
    .done(done), .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .busy(busy), .current_state(current_state)
  );

  // RAM with two-cycle read latency
  logic [15:0] ram_mem [256];
  logic [15:0] q1, q2;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    q1 <= ram_mem[ram_addr];
    q2 <= q1;
  end
  assign ram_q = q2;

  // reference model: access position within the grant (0 = idle)
  logic [15:0] ref_mem [256];
  int          m_phase, m_owner, m_last, m_runs;
  logic [15:0] m_rd;

  // last sampled outputs, for directed checks
  logic [2:0]  s_gnt, s_done;
  logic [15:0] s_rdata, s_wdata;
  logic [7:0]  s_addr;
  logic        s_we;
  logic [1:0]  s_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = 2; m_runs = 0; m_rd = 16'h0;
  endtask

  // sample and compare at negedge+1, advance the model, move to next negedge
  task automatic cycle();
    logic [2:0]  e_oh;
    logic [7:0]  a;
    bit          found;
    int          c;
    #1;
    e_oh = 3'b001 << m_owner;
    chk("gnt",   {29'b0, gnt},  (m_phase != 0) ? {29'b0, e_oh} : 32'h0);
    chk("done",  {29'b0, done}, (m_phase == 3) ? {29'b0, e_oh} : 32'h0);
    chk("rdata", {16'b0, rdata}, (m_phase == 3) ? {16'b0, m_rd} : 32'h0);
    chk("ram_we", {31'b0, ram_we}, (m_phase == 1) ? {31'b0, we[m_owner]} : 32'h0);
    chk("ram_addr", {24'b0, ram_addr}, (m_phase == 1) ? {24'b0, addr[m_owner*8 +: 8]} : 32'h0);
    chk("ram_wdata", {16'b0, ram_wdata}, (m_phase == 1) ? {16'b0, wdata[m_owner*16 +: 16]} : 32'h0);
    chk("busy",  {31'b0, busy}, (m_phase != 0) ? 32'h1 : 32'h0);
    chk("state", {30'b0, current_state}, 32'(m_phase));
    s_gnt = gnt; s_done = done; s_rdata = rdata; s_wdata = ram_wdata;
    s_addr = ram_addr; s_we = ram_we; s_state = current_state;
    if (m_phase == 1) begin
      a = addr[m_owner*8 +: 8];
      m_rd = ref_mem[a];
      if (we[m_owner]) ref_mem[a] = wdata[m_owner*16 +: 16];
    end
    if (program_reset) model_reset();
    else if (m_phase == 0) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        c = (m_last + k) % 3;
        if (!found && req[c]) begin
          found = 1; m_owner = c; m_phase = 1; m_runs = 1;
        end
      end
    end else if (m_phase == 3) begin
      m_last = m_owner;
      if (lock[m_owner] && req[m_owner] && m_runs < 4) begin
        m_phase = 1; m_runs++;
      end else begin
        m_phase = 0; m_runs = 0;
      end
    end else m_phase++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    program_reset = 1'b1; req = 3'b0; lock = 3'b0; we = 3'b0;
    cycle();
    program_reset = 1'b0;
  endtask

  initial begin
    logic [2:0] d_val[$];
    int         d_cyc[$];
    logic [2:0] exp_val[$];
    int         exp_cyc[$];

    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 16'(i) * 16'h0101 ^ 16'h5A5A;
      ref_mem[i] = 16'(i) * 16'h0101 ^ 16'h5A5A;
    end
    ram_mem[8'h12] = 16'hBEEF;
    ref_mem[8'h12] = 16'hBEEF;
    program_reset = 1'b1; req = 3'b0; lock = 3'b0; we = 3'b0;
    addr = 24'h0; wdata = 48'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    #1;
    chk("rst_gnt", {29'b0, gnt}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_we", {31'b0, ram_we}, 32'h0);
    chk("rst_rdata", {16'b0, rdata}, 32'h0);
    @(negedge clk);
    reset_cycle();

    // single read of 0x12 by requester 0; req dropped after grant
    req = 3'b001; addr = 24'h000012;
    cycle(); chk("rd_c1_gnt", {29'b0, s_gnt}, 32'h0);
    req = 3'b000;
    cycle(); chk("rd_c2_gnt", {29'b0, s_gnt}, 32'h1); chk("rd_c2_addr", {24'b0, s_addr}, 32'h12);
    cycle(); chk("rd_c3_gnt", {29'b0, s_gnt}, 32'h1);
    cycle(); chk("rd_c4_done", {29'b0, s_done}, 32'h1); chk("rd_c4_rdata", {16'b0, s_rdata}, 32'hBEEF);
    cycle(); chk("rd_c5_gnt", {29'b0, s_gnt}, 32'h0);

    // write 0x1234 to 0x05 by requester 1, then read it back
    req = 3'b010; we = 3'b010; addr = 24'h000500; wdata = 48'h0000_1234_0000;
    cycle();
    req = 3'b000;
    cycle(); chk("wr_we", {31'b0, s_we}, 32'h1); chk("wr_addr", {24'b0, s_addr}, 32'h05);
    chk("wr_wdata", {16'b0, s_wdata}, 32'h1234);
    cycle(); chk("wr_we_off", {31'b0, s_we}, 32'h0);
    cycle(); cycle();
    req = 3'b010; we = 3'b000;
    cycle();
    req = 3'b000;
    cycle(); cycle();
    cycle(); chk("wr_readback", {16'b0, s_rdata}, 32'h1234);

    // contention: all requesters from reset
    reset_cycle();
    req = 3'b111; d_val.delete(); d_cyc.delete();
    for (int i = 1; i <= 24; i++) begin
      cycle();
      if (s_done != 3'b0) begin d_val.push_back(s_done); d_cyc.push_back(i); end
    end
    chk("cont_count", 32'(d_val.size()), 32'd6);
    for (int k = 0; k < d_val.size() && k < 6; k++) begin
      chk("cont_order", {29'b0, d_val[k]}, {29'b0, 3'b001 << (k % 3)});
      chk("cont_cycle", 32'(d_cyc[k]), 32'(4 * (k + 1)));
    end

    // lock limit: requester 0 chains four accesses, then requester 1
    reset_cycle();
    req = 3'b111; lock = 3'b001; d_val.delete(); d_cyc.delete();
    exp_val = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    exp_cyc = '{4, 7, 10, 13, 17};
    for (int i = 1; i <= 17; i++) begin
      cycle();
      if (s_done != 3'b0) begin d_val.push_back(s_done); d_cyc.push_back(i); end
    end
    chk("lock_count", 32'(d_val.size()), 32'd5);
    for (int k = 0; k < d_val.size() && k < 5; k++) begin
      chk("lock_order", {29'b0, d_val[k]}, {29'b0, exp_val[k]});
      chk("lock_cycle", 32'(d_cyc[k]), 32'(exp_cyc[k]));
    end
    req = 3'b000; lock = 3'b000;
    repeat (4) cycle();

    // read-modify-write by requester 0 while requester 1 waits
    reset_cycle();
    req = 3'b011; lock = 3'b001; addr = 24'h000040; wdata = 48'h0000_0000_CAFE;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      if (i >= 2) chk("rmw_gnt_rd", {29'b0, s_gnt}, 32'h1);
    end
    we = 3'b001; lock = 3'b000;
    for (int i = 5; i <= 7; i++) begin
      cycle();
      chk("rmw_gnt_wr", {29'b0, s_gnt}, 32'h1);
      if (i == 5) chk("rmw_we", {31'b0, s_we}, 32'h1);
    end
    req = 3'b000; we = 3'b000;
    cycle(); chk("rmw_release", {29'b0, s_gnt}, 32'h0);
    repeat (4) cycle();

    // reset in WAIT aborts the access; requester 2 then 0 served
    req = 3'b001;
    cycle();
    req = 3'b000;
    cycle();
    program_reset = 1'b1;
    cycle(); chk("abort_wait_state", {30'b0, s_state}, 32'h2);
    program_reset = 1'b0; req = 3'b100;
    cycle(); chk("abort_idle", {30'b0, s_state}, 32'h0); chk("abort_done", {29'b0, s_done}, 32'h0);
    req = 3'b001; d_val.delete();
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (s_done != 3'b0) d_val.push_back(s_done);
    end
    chk("abort_count", 32'(d_val.size()), 32'd2);
    if (d_val.size() == 2) begin
      chk("abort_first", {29'b0, d_val[0]}, 32'h4);
      chk("abort_second", {29'b0, d_val[1]}, 32'h1);
    end
    req = 3'b000;
    repeat (5) cycle();

    // random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      program_reset = ($urandom_range(0, 49) == 0);
      req   = 3'($urandom_range(0, 7));
      lock  = 3'($urandom_range(0, 7));
      we    = 3'($urandom_range(0, 7));
      addr  = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
      wdata = {16'($urandom()), 16'($urandom()), 16'($urandom())};
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
